// File: rtl/modexp_stream_if.sv
// modexp_stream_if: operand/result handshake bundle for modexp_stream.
// The master drives operands and consumes results; the slave is the exponentiator.
interface modexp_stream_if #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     m;
  logic [EXP_WIDTH-1:0] e;
  logic [WIDTH-1:0]     n;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 err;
  logic                 busy;

  modport master (
    output in_valid, m, e, n, out_ready,
    input  in_ready, out_valid, result, err, busy
  );

  modport slave (
    input  in_valid, m, e, n, out_ready,
    output in_ready, out_valid, result, err, busy
  );
endinterface

// File: rtl/modexp_stream.sv
// modexp_stream: sequential modular exponentiator, result = m^e mod n.
// Valid/ready handshake on operands and result, one operation in flight.
// Default build: left-to-right square-and-multiply with leading-zero skip.
// Optional macro MODEXP_CONST_TIME_EN: Montgomery ladder over all EXP_WIDTH
// bits, fixed latency independent of the exponent value.
// Every modular product uses a bit-serial interleaved multiplier, one
// multiplier bit per cycle, multiplier MSB first.
module modexp_stream #(
  parameter int WIDTH     = 16,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  modexp_stream_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int TW    = WIDTH + 2;

  typedef enum logic [2:0] {IDLE, LOAD, SQR, MUL, DONE} state_t;
  state_t state, state_nxt;

  // captured operands and working values
  logic [WIDTH-1:0]     m_r, n_r, acc, p;
  logic [EXP_WIDTH-1:0] e_r;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic                 err_flag;
`ifdef MODEXP_CONST_TIME_EN
  logic [WIDTH-1:0]     r1;
`endif

  // registered outputs
  logic                 in_ready_r, out_valid_r, busy_r, err_r;
  logic [WIDTH-1:0]     result_r;

  logic                 accept, last_step, ebit, op_err;
  logic [WIDTH-1:0]     mx, ma, prod;

  // One interleaved step: 2*p plus optional addend, then at most two
  // conditional subtractions. With p, a < n the sum is < 3n, so two
  // subtractions always leave a fully reduced value.
  function automatic logic [WIDTH-1:0] mod_step(
    input logic [WIDTH-1:0] pv,
    input logic             add,
    input logic [WIDTH-1:0] av,
    input logic [WIDTH-1:0] nv
  );
    logic [TW-1:0] t, nn;
    nn = {2'b00, nv};
    t  = {1'b0, pv, 1'b0} + (add ? {2'b00, av} : {TW{1'b0}});
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

`ifndef MODEXP_CONST_TIME_EN
  logic             e_zero;
  logic [IDX_W-1:0] msb_idx;

  // Priority encoder: position of the highest set exponent bit.
  function automatic logic [IDX_W-1:0] msb_index(input logic [EXP_WIDTH-1:0] ev);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXP_WIDTH; i++) begin
      if (ev[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign e_zero  = (e_r == '0);
  assign msb_idx = msb_index(e_r);
`endif

  assign accept    = bus.in_valid & in_ready_r;
  assign last_step = (cnt == '0);
  assign ebit      = e_r[idx];
  assign op_err    = (n_r[WIDTH-1:1] == '0) || (m_r >= n_r);

  // Multiplier operand selection: mx supplies the serial bits, ma the addend.
  always_comb begin
    mx = acc;
    ma = acc;
`ifdef MODEXP_CONST_TIME_EN
    if (state == MUL) begin
      mx = acc;
      ma = r1;
    end else if (ebit) begin
      mx = r1;
      ma = r1;
    end
`else
    if (state == MUL) ma = m_r;
`endif
  end

  assign prod = mod_step(p, mx[cnt], ma, n_r);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = LOAD;
`ifdef MODEXP_CONST_TIME_EN
      LOAD: state_nxt = op_err ? DONE : MUL;
      MUL:  if (last_step) state_nxt = SQR;
      SQR:  if (last_step) state_nxt = (idx == '0) ? DONE : MUL;
`else
      LOAD: state_nxt = (op_err || e_zero) ? DONE : SQR;
      SQR: begin
        if (last_step) begin
          if (ebit)               state_nxt = MUL;
          else if (idx == '0)     state_nxt = DONE;
          else                    state_nxt = SQR;
        end
      end
      MUL:  if (last_step) state_nxt = (idx == '0) ? DONE : SQR;
`endif
      DONE: if (out_valid_r && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and output registers; result/err latch when out_valid rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      result_r    <= '0;
    end else begin
      in_ready_r <= (state_nxt == IDLE);
      if (accept) busy_r <= 1'b1;
      if (state == DONE) begin
        if (!out_valid_r) begin
          out_valid_r <= 1'b1;
          busy_r      <= 1'b0;
          err_r       <= err_flag;
          result_r    <= err_flag ? '0 : acc;
        end else if (bus.out_ready) begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  // Datapath: operand capture, serial multiplier and exponent bit walk.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_r <= bus.m;
      e_r <= bus.e;
      n_r <= bus.n;
    end
    case (state)
      LOAD: begin
        acc      <= WIDTH'(1);
        p        <= '0;
        cnt      <= CNT_W'(WIDTH - 1);
        err_flag <= op_err;
`ifdef MODEXP_CONST_TIME_EN
        r1       <= m_r;
        idx      <= IDX_W'(EXP_WIDTH - 1);
`else
        idx      <= msb_idx;
`endif
      end
      SQR, MUL: begin
        if (last_step) begin
          p   <= '0;
          cnt <= CNT_W'(WIDTH - 1);
`ifdef MODEXP_CONST_TIME_EN
          if (state == MUL) begin
            if (ebit) acc <= prod;
            else      r1  <= prod;
          end else begin
            if (ebit) r1  <= prod;
            else      acc <= prod;
            idx <= idx - 1'b1;
          end
`else
          acc <= prod;
          if (state == MUL || !ebit) idx <= idx - 1'b1;
`endif
        end else begin
          p   <= prod;
          cnt <= cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.err       = err_r;
  assign bus.busy      = busy_r;
endmodule
